ncl_word_io_driver: RTL

// Clocked environment for the dual-rail NCL digit-pipelined adder: transmits binary operands as

---
 rtl/ncl_word_io_driver.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ncl_word_io_driver.sv
`default_nettype none
// ============================================================================
// Module : ncl_word_io_driver
// Brief  : Clocked source/sink for a dual-rail NCL adder; optional protocol
//          checker enabled by defining NCL_PROTO_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module ncl_word_io_driver #(
  parameter int DIGITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                init_n,
  input  logic                start,
  input  logic [DIGITS-1:0]   op_a,
  input  logic [DIGITS-1:0]   op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [DIGITS-1:0]   result,
  output logic                cout,
  output logic [2*DIGITS-1:0] A,
  output logic [2*DIGITS-1:0] B,
  output logic [1:0]          carryin,
  input  logic                carryinCOMP,
  input  logic [2*DIGITS-1:0] sum,
  input  logic [1:0]          carryout,
  output logic                sumCOMP,
  output logic                proto_err
);

  localparam int c_DW = 2*DIGITS + 2;
  localparam int c_SW = c_DW + 1;

  typedef enum logic [2:0] {
    SRC_IDLE    = 3'd0,
    SRC_DATA    = 3'd1,
    SRC_WAIT_HI = 3'd2,
    SRC_NULL    = 3'd3,
    SRC_WAIT_LO = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    S_WAIT_DATA = 2'd0,
    S_WAIT_NULL = 2'd1,
    S_WAIT_SRC  = 2'd2
  } snk_t;

  function automatic logic [2*DIGITS-1:0] f_rail(input logic [DIGITS-1:0] v);
    logic [2*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  logic [c_SW-1:0]     r_sync [SYNC_STAGES];
  logic [c_DW-1:0]     r_rx_prev;
  logic [2*DIGITS-1:0] r_a, r_b;
  logic [1:0]          r_ci;
  logic [DIGITS-1:0]   r_result;
  logic                r_cout, r_sumcomp, r_done, r_busy;
  src_t                r_src;
  snk_t                r_snk;

  logic                w_ci_s;
  logic [c_DW-1:0]     w_rx;
  logic [DIGITS:0]     w_pair_one, w_pair_zero;
  logic [DIGITS-1:0]   w_res;
  logic                w_stable, w_data_cplt, w_null_cplt, w_accept;

  // Asynchronous adder signals are only ever used after the synchronizer.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= {carryinCOMP, carryout, sum};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_ci_s = r_sync[SYNC_STAGES-1][c_SW-1];
  assign w_rx   = r_sync[SYNC_STAGES-1][c_DW-1:0];

  always_comb begin
    w_pair_one  = '0;
    w_pair_zero = '0;
    w_res       = '0;
    for (int i = 0; i <= DIGITS; i++) begin
      w_pair_one[i]  = w_rx[2*i] ^ w_rx[2*i+1];
      w_pair_zero[i] = ~(w_rx[2*i] | w_rx[2*i+1]);
    end
    for (int i = 0; i < DIGITS; i++) w_res[i] = w_rx[2*i+1];
  end

  // A wavefront counts only once two consecutive samples agree.
  assign w_stable    = (w_rx == r_rx_prev);
  assign w_data_cplt = (&w_pair_one) && w_stable;
  assign w_null_cplt = (&w_pair_zero) && w_stable;
  assign w_accept    = start && !r_busy && (r_src == SRC_IDLE);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_src <= SRC_IDLE;
      r_a   <= '0;
      r_b   <= '0;
      r_ci  <= '0;
    end else begin
      case (r_src)
        SRC_IDLE: if (w_accept) begin
          r_a   <= f_rail(op_a);
          r_b   <= f_rail(op_b);
          r_ci  <= {cin, ~cin};
          r_src <= SRC_DATA;
        end
        SRC_DATA:    r_src <= SRC_WAIT_HI;
        SRC_WAIT_HI: if (w_ci_s) begin
          r_a   <= '0;
          r_b   <= '0;
          r_ci  <= '0;
          r_src <= SRC_NULL;
        end
        SRC_NULL:    r_src <= SRC_WAIT_LO;
        SRC_WAIT_LO: if (!w_ci_s) r_src <= SRC_IDLE;
        default:     r_src <= SRC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_snk     <= S_WAIT_DATA;
      r_sumcomp <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_rx_prev <= '0;
    end else begin
      r_rx_prev <= w_rx;
      r_done    <= 1'b0;
      case (r_snk)
        S_WAIT_DATA: if (w_data_cplt) begin
          r_result  <= w_res;
          r_cout    <= w_rx[c_DW-1];
          r_sumcomp <= 1'b1;
          r_snk     <= S_WAIT_NULL;
        end
        S_WAIT_NULL: if (w_null_cplt) begin
          r_sumcomp <= 1'b0;
          r_snk     <= S_WAIT_SRC;
        end
        S_WAIT_SRC: if (r_src == SRC_IDLE) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_snk  <= S_WAIT_DATA;
        end
        default: r_snk <= S_WAIT_DATA;
      endcase
      if (w_accept) r_busy <= 1'b1;
    end
  end

`ifdef NCL_PROTO_CHECK_EN
  logic            r_err, r_ci_prev;
  logic [DIGITS:0] w_prev_zero;
  logic            w_both, w_ci_rise, w_reappear;

  always_comb begin
    w_both      = 1'b0;
    w_prev_zero = '0;
    for (int i = 0; i <= DIGITS; i++) begin
      w_both         = w_both | (w_rx[2*i] & w_rx[2*i+1]);
      w_prev_zero[i] = ~(r_rx_prev[2*i] | r_rx_prev[2*i+1]);
    end
  end

  // A pair leaving NULL while the sink is draining means DATA came back.
  assign w_reappear = (r_snk == S_WAIT_NULL) && (|(w_prev_zero & ~w_pair_zero));
  assign w_ci_rise  = w_ci_s && !r_ci_prev && ((r_src == SRC_IDLE) || (r_src == SRC_NULL));

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_err     <= 1'b0;
      r_ci_prev <= 1'b0;
    end else begin
      r_ci_prev <= w_ci_s;
      if (w_both || w_ci_rise || w_reappear) r_err <= 1'b1;
    end
  end

  assign proto_err = r_err;
`else
  assign proto_err = 1'b0;
`endif

  assign A       = r_a;
  assign B       = r_b;
  assign carryin = r_ci;
  assign sumCOMP = r_sumcomp;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign cout    = r_cout;

endmodule
`default_nettype wire
